lock_sequencer: RTL and testbench

LOCK_SEQUENCER -- requirements
Module: lock_sequencer

---
 rtl/lock_pkg.sv | 20 ++
 rtl/seg7_enc.sv | 11 +
 rtl/lock_sequencer.sv | 158 +++++++++++++++
 tb/tb_lock_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the two-digit code lock: FSM states,
// blank display value and the hex-to-7-segment lookup table.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT1    = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; dp held off (1) for every digit.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/seg7_enc.sv
// Hex digit to active-low 7-segment pattern (dp off).
module seg7_enc
    import lock_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/lock_sequencer.sv
// Two-digit code lock with entry timeout, timed unlock and failure lockout.
// Optional macro LOCK_SEQUENCER_PROG_EN adds a code-programming port used while open.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter logic [7:0] CODE           = 8'hA5,
    parameter int         MAX_FAILS      = 3,
    parameter int         OPEN_CYCLES    = 16,
    parameter int         LOCKOUT_CYCLES = 64,
    parameter int         ENTRY_TO       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dig,
    input  logic       dig_vld,
`ifdef LOCK_SEQUENCER_PROG_EN
    input  logic       prog_vld,
    input  logic [7:0] prog_code,
`endif
    output logic       unlocked,
    output logic       alarm,
    output logic       busy,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [3:0] fail_cnt
);

    localparam int TMAX_A = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX   = (TMAX_A > ENTRY_TO) ? TMAX_A : ENTRY_TO;
    localparam int TW     = $clog2(TMAX + 1);

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next, timer_inc;
    logic [3:0]    fail_reg, fail_next, fail_inc;
    logic [3:0]    d0_reg, d0_next, d1_reg, d1_next;
    logic          show1_reg, show1_next, show2_reg, show2_next;
    logic [7:0]    code_act;
    logic [7:0]    enc1, enc2;

`ifdef LOCK_SEQUENCER_PROG_EN
    logic [7:0] code_reg, code_next;
    assign code_act = code_reg;
`else
    assign code_act = CODE;
`endif

    // Saturating so a stalled timer can never wrap back into range.
    assign timer_inc = (timer_reg == {TW{1'b1}}) ? timer_reg : timer_reg + TW'(1);
    assign fail_inc  = fail_reg + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            fail_reg  <= '0;
            d0_reg    <= '0;
            d1_reg    <= '0;
            show1_reg <= 1'b0;
            show2_reg <= 1'b0;
`ifdef LOCK_SEQUENCER_PROG_EN
            code_reg  <= CODE;
`endif
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            fail_reg  <= fail_next;
            d0_reg    <= d0_next;
            d1_reg    <= d1_next;
            show1_reg <= show1_next;
            show2_reg <= show2_next;
`ifdef LOCK_SEQUENCER_PROG_EN
            code_reg  <= code_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_inc;
        fail_next  = fail_reg;
        d0_next    = d0_reg;
        d1_next    = d1_reg;
        show1_next = show1_reg;
        show2_next = show2_reg;
`ifdef LOCK_SEQUENCER_PROG_EN
        code_next  = code_reg;
`endif
        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (dig_vld) begin
                    d0_next    = dig;
                    show1_next = 1'b1;
                    show2_next = 1'b0;
                    state_next = GOT1;
                end
            end
            GOT1: begin
                // Expiry is checked first so a coincident strobe is dropped.
                if (timer_reg == TW'(ENTRY_TO - 1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                    show1_next = 1'b0;
                    show2_next = 1'b0;
                end else if (dig_vld) begin
                    d1_next    = dig;
                    show2_next = 1'b1;
                    timer_next = '0;
                    if ({d0_reg, dig} == code_act) begin
                        state_next = OPEN;
                        fail_next  = '0;
                    end else begin
                        fail_next  = fail_inc;
                        state_next = (fail_inc == 4'(MAX_FAILS)) ? LOCKOUT : IDLE;
                    end
                end
            end
            OPEN: begin
                if (timer_reg == TW'(OPEN_CYCLES - 1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                    show1_next = 1'b0;
                    show2_next = 1'b0;
                end
`ifdef LOCK_SEQUENCER_PROG_EN
                if (prog_vld) begin
                    code_next = prog_code;
                end
`endif
            end
            LOCKOUT: begin
                if (timer_reg == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                    fail_next  = '0;
                    show1_next = 1'b0;
                    show2_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    seg7_enc u_enc1 (.hex(d0_reg), .seg(enc1));
    seg7_enc u_enc2 (.hex(d1_reg), .seg(enc2));

    // Outputs decode only registered state, so nothing is combinational from inputs.
    assign unlocked = (state_reg == OPEN);
    assign alarm    = (state_reg == LOCKOUT);
    assign busy     = (state_reg == OPEN) || (state_reg == LOCKOUT);
    assign seg1     = show1_reg ? enc1 : SEG_BLANK;
    assign seg2     = show2_reg ? enc2 : SEG_BLANK;
    assign fail_cnt = fail_reg;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed scenarios plus randomized
// code entries checked against a transaction-level model of the lock rules.
module tb_lock_sequencer;

    localparam int OPEN_C = 16;
    localparam int LOCK_C = 64;
    localparam int ETO    = 32;
    localparam int MAXF   = 3;
    localparam logic [7:0] KEY = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] dig = 4'h0;
    logic       dig_vld = 1'b0;
    logic       unlocked, alarm, busy;
    logic [7:0] seg1, seg2;
    logic [3:0] fail_cnt;

    int total = 0;
    int bad   = 0;
    int exp_fail = 0;

    lock_sequencer dut (
        .clk(clk), .rst_n(rst_n), .dig(dig), .dig_vld(dig_vld),
        .unlocked(unlocked), .alarm(alarm), .busy(busy),
        .seg1(seg1), .seg2(seg2), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    // Independent segment model: active-high gfedcba, inverted, dp forced off.
    function automatic logic [7:0] pat(input logic [3:0] h);
        logic [6:0] on;
        case (h)
            4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
            4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
            4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
            4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
        endcase
        return 8'hFF ^ {1'b0, on};
    endfunction

    // Strobe one digit across the next rising edge; returns 1 time unit after it.
    task automatic pulse(input logic [3:0] d);
        dig = d;
        dig_vld = 1'b1;
        @(posedge clk);
        #1;
        dig_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic measure(input bit use_alarm, output int n);
        n = 0;
        while (((use_alarm ? alarm : unlocked) === 1'b1) && n < 300) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({unlocked, alarm, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {unlocked, alarm, busy}); end
        total++; if (fail_cnt !== 4'd0) begin bad++; $display("FAIL reset_fail got=%0d want=0", fail_cnt); end
        total++; if ({seg1, seg2} !== 16'hFFFF) begin bad++; $display("FAIL reset_segs got=%h want=ffff", {seg1, seg2}); end
        idle(3);
        rst_n = 1'b1;
        exp_fail = 0;
        idle(1);
        $display("reset: released");
    endtask

    task automatic test_unlock;
        int n;
        pulse(4'hA);
        total++; if (seg1 !== pat(4'hA) || seg2 !== 8'hFF) begin bad++; $display("FAIL first_digit_segs got=%h/%h want=%h/ff", seg1, seg2, pat(4'hA)); end
        total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL early_unlock got=%b want=0", unlocked); end
        pulse(4'h5);
        total++; if ({unlocked, busy, alarm} !== 3'b110) begin bad++; $display("FAIL unlock_flags got=%b want=110", {unlocked, busy, alarm}); end
        total++; if (seg1 !== pat(4'hA) || seg2 !== pat(4'h5)) begin bad++; $display("FAIL unlock_segs got=%h/%h want=%h/%h", seg1, seg2, pat(4'hA), pat(4'h5)); end
        measure(1'b0, n);
        total++; if (n != OPEN_C) begin bad++; $display("FAIL open_len got=%0d want=%0d", n, OPEN_C); end
        total++; if ({seg1, seg2, busy} !== {16'hFFFF, 1'b0}) begin bad++; $display("FAIL open_exit got=%h/%h busy=%b want=ff/ff busy=0", seg1, seg2, busy); end
        exp_fail = 0;
        $display("unlock: open for %0d cycles", n);
    endtask

    task automatic test_lockout;
        int n;
        for (int k = 1; k <= MAXF; k++) begin
            pulse(4'hA);
            pulse(4'hA);
            total++; if (fail_cnt !== 4'(k)) begin bad++; $display("FAIL fail_step got=%0d want=%0d", fail_cnt, k); end
        end
        total++; if ({alarm, busy, unlocked} !== 3'b110) begin bad++; $display("FAIL lockout_flags got=%b want=110", {alarm, busy, unlocked}); end
        measure(1'b1, n);
        total++; if (n != LOCK_C) begin bad++; $display("FAIL lockout_len got=%0d want=%0d", n, LOCK_C); end
        total++; if (fail_cnt !== 4'd0 || {seg1, seg2} !== 16'hFFFF) begin bad++; $display("FAIL lockout_exit got=%0d %h/%h want=0 ff/ff", fail_cnt, seg1, seg2); end
        exp_fail = 0;
        $display("lockout: alarm for %0d cycles", n);
    endtask

    task automatic test_timeout;
        int n;
        pulse(4'hA); pulse(4'hA);
        exp_fail = 1;
        pulse(4'hA);
        idle(ETO - 1);
        total++; if (seg1 !== pat(4'hA)) begin bad++; $display("FAIL pre_timeout_seg got=%h want=%h", seg1, pat(4'hA)); end
        idle(1);
        total++; if ({seg1, seg2} !== 16'hFFFF || fail_cnt !== 4'(exp_fail)) begin bad++; $display("FAIL timeout got=%h/%h fail=%0d want=ff/ff fail=%0d", seg1, seg2, fail_cnt, exp_fail); end
        // Second digit landing on the expiry cycle must be dropped.
        pulse(4'hA);
        idle(ETO - 1);
        pulse(4'h5);
        total++; if (unlocked !== 1'b0 || {seg1, seg2} !== 16'hFFFF) begin bad++; $display("FAIL expiry_wins got=%b %h/%h want=0 ff/ff", unlocked, seg1, seg2); end
        pulse(4'hA);
        idle(ETO - 2);
        pulse(4'h5);
        total++; if (unlocked !== 1'b1 || fail_cnt !== 4'd0) begin bad++; $display("FAIL late_unlock got=%b fail=%0d want=1 fail=0", unlocked, fail_cnt); end
        measure(1'b0, n);
        total++; if (n != OPEN_C) begin bad++; $display("FAIL late_open_len got=%0d want=%0d", n, OPEN_C); end
        exp_fail = 0;
        $display("timeout: checked expiry and last valid slot");
    endtask

    task automatic test_busy_ignore;
        int errs;
        pulse(4'hA); pulse(4'h5);
        errs = 0;
        for (int i = 0; i < OPEN_C; i++) begin
            if (unlocked !== 1'b1 || seg1 !== pat(4'hA) || seg2 !== pat(4'h5) || fail_cnt !== 4'd0) errs++;
            dig = 4'($urandom_range(15));
            dig_vld = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        dig_vld = 1'b0;
        total++; if (errs != 0) begin bad++; $display("FAIL open_ignore got=%0d bad cycles want=0", errs); end
        total++; if (unlocked !== 1'b0 || {seg1, seg2} !== 16'hFFFF) begin bad++; $display("FAIL open_ignore_exit got=%b %h/%h want=0 ff/ff", unlocked, seg1, seg2); end
        for (int k = 0; k < MAXF; k++) begin pulse(4'h3); pulse(4'h7); end
        errs = 0;
        for (int i = 0; i < LOCK_C; i++) begin
            if (alarm !== 1'b1 || seg1 !== pat(4'h3) || seg2 !== pat(4'h7) || fail_cnt !== 4'(MAXF)) errs++;
            dig = 4'($urandom_range(15));
            dig_vld = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        dig_vld = 1'b0;
        total++; if (errs != 0) begin bad++; $display("FAIL lock_ignore got=%0d bad cycles want=0", errs); end
        total++; if (alarm !== 1'b0 || fail_cnt !== 4'd0 || {seg1, seg2} !== 16'hFFFF) begin bad++; $display("FAIL lock_ignore_exit got=%b %0d %h/%h want=0 0 ff/ff", alarm, fail_cnt, seg1, seg2); end
        exp_fail = 0;
        $display("busy_ignore: strobes during open and lockout");
    endtask

    task automatic test_reset_mid_lockout;
        int n;
        for (int k = 0; k < MAXF; k++) begin pulse(4'h1); pulse(4'h2); end
        idle(19);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({alarm, busy, fail_cnt} !== 6'd0) begin bad++; $display("FAIL mid_reset_flags got=%b %0d want=0 0", {alarm, busy}, fail_cnt); end
        total++; if ({seg1, seg2} !== 16'hFFFF) begin bad++; $display("FAIL mid_reset_segs got=%h/%h want=ff/ff", seg1, seg2); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_fail = 0;
        pulse(4'hA); pulse(4'h5);
        measure(1'b0, n);
        total++; if (n != OPEN_C) begin bad++; $display("FAIL post_reset_open got=%0d want=%0d", n, OPEN_C); end
        $display("reset_mid_lockout: recovered, open %0d cycles", n);
    endtask

    task automatic test_random;
        logic [3:0] a, b;
        int g, n;
        for (int t = 0; t < 40; t++) begin
            a = ($urandom_range(1) == 1) ? 4'hA : 4'($urandom_range(15));
            b = ($urandom_range(1) == 1) ? 4'h5 : 4'($urandom_range(15));
            g = ($urandom_range(7) == 0) ? ETO : int'($urandom_range(ETO - 1, 1));
            idle(int'($urandom_range(2)));
            pulse(a);
            idle(g - 1);
            pulse(b);
            if (g >= ETO) begin
                total++; if ({unlocked, alarm} !== 2'b00 || {seg1, seg2} !== 16'hFFFF || fail_cnt !== 4'(exp_fail)) begin bad++; $display("FAIL rnd_timeout txn=%0d got=%b %h/%h %0d want=00 ff/ff %0d", t, {unlocked, alarm}, seg1, seg2, fail_cnt, exp_fail); end
                $display("txn %0d: %h,%h gap=%0d -> timeout", t, a, b, g);
            end else if ({a, b} == KEY) begin
                total++; if (unlocked !== 1'b1 || fail_cnt !== 4'd0) begin bad++; $display("FAIL rnd_unlock txn=%0d got=%b %0d want=1 0", t, unlocked, fail_cnt); end
                measure(1'b0, n);
                total++; if (n != OPEN_C) begin bad++; $display("FAIL rnd_open_len txn=%0d got=%0d want=%0d", t, n, OPEN_C); end
                exp_fail = 0;
                $display("txn %0d: %h,%h gap=%0d -> open", t, a, b, g);
            end else begin
                exp_fail++;
                if (exp_fail == MAXF) begin
                    total++; if (alarm !== 1'b1 || fail_cnt !== 4'(MAXF)) begin bad++; $display("FAIL rnd_lockout txn=%0d got=%b %0d want=1 %0d", t, alarm, fail_cnt, MAXF); end
                    measure(1'b1, n);
                    total++; if (n != LOCK_C || fail_cnt !== 4'd0) begin bad++; $display("FAIL rnd_lock_len txn=%0d got=%0d/%0d want=%0d/0", t, n, fail_cnt, LOCK_C); end
                    exp_fail = 0;
                    $display("txn %0d: %h,%h gap=%0d -> lockout", t, a, b, g);
                end else begin
                    total++; if (fail_cnt !== 4'(exp_fail) || unlocked !== 1'b0 || seg1 !== pat(a) || seg2 !== pat(b)) begin bad++; $display("FAIL rnd_wrong txn=%0d got=%0d %b %h/%h want=%0d 0 %h/%h", t, fail_cnt, unlocked, seg1, seg2, exp_fail, pat(a), pat(b)); end
                    $display("txn %0d: %h,%h gap=%0d -> wrong, fails=%0d", t, a, b, g, exp_fail);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_unlock;
        test_lockout;
        test_timeout;
        test_busy_ignore;
        test_reset_mid_lockout;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
